// File: rtl/ad_avg_accum_if.sv
// ---------------------------------------------------------------------------
// ad_avg_accum_if
// Purpose : averaged-waveform output stream of ad_avg_accum. One word per
//           accepted valid/ready handshake.
// Signals :
//   avg_valid  master->slave  word valid
//   avg_ready  slave->master  consumer accepts the word this cycle
//   avg_data   master->slave  averaged sample (DATA_W)
//   avg_addr   master->slave  sample index of avg_data (ADDR_W)
//   avg_last   master->slave  high with the word at the final index
// ---------------------------------------------------------------------------
interface ad_avg_accum_if #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 13
);
  logic              avg_valid;
  logic              avg_ready;
  logic [DATA_W-1:0] avg_data;
  logic [ADDR_W-1:0] avg_addr;
  logic              avg_last;

  modport master (
    output avg_valid,
    output avg_data,
    output avg_addr,
    output avg_last,
    input  avg_ready
  );

  modport slave (
    input  avg_valid,
    input  avg_data,
    input  avg_addr,
    input  avg_last,
    output avg_ready
  );
endinterface

// File: rtl/ad_avg_accum.sv
// ---------------------------------------------------------------------------
// ad_avg_accum
// Purpose : coherent averager. Sums 2^AVG_LOG2 consecutive AD bursts index by
//           index into an accumulator RAM, then streams acc[i] >> AVG_LOG2
//           out over a valid/ready handshake while holding Avg_Sram_full.
// Ports   :
//   clk_sample     in   sample clock, rising edge
//   reset          in   synchronous active-high reset
//   AD_data_valid  in   burst qualifier (one contiguous high run per burst)
//   AD_data        in   unsigned sample, DATA_W bits
//   avg_start      in   one-cycle pulse, starts an average (IDLE only)
//   Avg_Sram_full  out  high from DUMP entry until the last word is taken
//   busy           out  high in every state except IDLE
//   short_err      out  sticky: a burst of the current average was short
//   avg_if         master modport of ad_avg_accum_if (output stream)
// ---------------------------------------------------------------------------
module ad_avg_accum #(
  parameter int DATA_W   = 10,
  parameter int ADDR_W   = 13,
  parameter int DEPTH    = 8192,
  parameter int AVG_LOG2 = 4
) (
  input  logic              clk_sample,
  input  logic              reset,
  input  logic              AD_data_valid,
  input  logic [DATA_W-1:0] AD_data,
  input  logic              avg_start,
  output logic              Avg_Sram_full,
  output logic              busy,
  output logic              short_err,
  ad_avg_accum_if.master    avg_if
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  // Sample/read counters need one extra bit so they can hold DEPTH itself.
  localparam int KW    = ADDR_W + 1;
  localparam int BC_W  = AVG_LOG2 + 1;

  localparam logic [KW-1:0]     DEPTH_K = KW'(DEPTH);
  localparam logic [BC_W-1:0]   NBURST  = BC_W'(1) << AVG_LOG2;
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_ACCUM,
    S_DUMP
  } state_t;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t            state_q;
  logic [BC_W-1:0]   burst_cnt_q;
  logic              short_err_q;
  logic              full_q;
  logic              busy_q;
  logic              valid_prev_q;
  logic [KW-1:0]     k_q;

  // accumulate write stage (cycle t+1 of the pipeline)
  logic              wr_pend_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] samp_q;
  logic              first_q;

  // accumulator RAM
  logic [ACC_W-1:0]  mem [0:DEPTH-1];
  logic [ACC_W-1:0]  rd_data_q;

  // dump read side
  logic [KW-1:0]     rd_cnt_q;
  logic              rd_pend_q;
  logic [ADDR_W-1:0] rd_pend_addr_q;

  // output register plus skid register
  logic              out_v_q;
  logic [DATA_W-1:0] out_data_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic              out_last_q;
  logic              skid_v_q;
  logic [DATA_W-1:0] skid_data_q;
  logic [ADDR_W-1:0] skid_addr_q;
  logic              skid_last_q;

  // -------------------------------------------------------------------------
  // Combinational control
  // -------------------------------------------------------------------------
  logic              rising_d;
  logic              take_d;
  logic [ADDR_W-1:0] take_addr_d;
  logic              pop_d;
  logic [1:0]        occ_d;
  logic              issue_d;
  logic [ADDR_W-1:0] ram_ra_d;
  logic [ACC_W-1:0]  wr_sum_d;
  logic [DATA_W-1:0] in_data_d;
  logic              in_last_d;

  always_comb begin
    rising_d    = AD_data_valid && !valid_prev_q;
    take_d      = 1'b0;
    take_addr_d = '0;
    if (state_q == S_ARM) begin
      // A burst already running when we armed never produces a rising edge
      // here, so it is skipped in full.
      take_d      = rising_d;
      take_addr_d = '0;
    end else if (state_q == S_ACCUM) begin
      take_d      = AD_data_valid && (k_q < DEPTH_K);
      take_addr_d = k_q[ADDR_W-1:0];
    end

    pop_d = out_v_q && avg_if.avg_ready;

    // Words either held or already in flight from the RAM. A new read is
    // only issued when it is guaranteed a slot (output or skid) on landing.
    occ_d   = 2'(out_v_q) + 2'(skid_v_q) + 2'(rd_pend_q);
    issue_d = (state_q == S_DUMP) && (rd_cnt_q < DEPTH_K) &&
              ((occ_d < 2'd2) || ((occ_d == 2'd2) && pop_d));

    ram_ra_d = (state_q == S_DUMP) ? rd_cnt_q[ADDR_W-1:0] : take_addr_d;

    // First burst of an average overwrites, so no clear pass is needed.
    wr_sum_d = first_q ? ACC_W'(samp_q) : (rd_data_q + ACC_W'(samp_q));

    in_data_d = rd_data_q[ACC_W-1:AVG_LOG2];
    in_last_d = (rd_pend_addr_q == LAST_A);
  end

  // -------------------------------------------------------------------------
  // Accumulator RAM: one write port, one registered read port.
  // Reads and writes in the same cycle always target different addresses.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_sample) begin
    if (wr_pend_q) begin
      mem[wr_addr_q] <= wr_sum_d;
    end
    rd_data_q <= mem[ram_ra_d];
  end

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_sample) begin
    if (reset) begin
      state_q     <= S_IDLE;
      burst_cnt_q <= '0;
      short_err_q <= 1'b0;
      full_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (avg_start) begin
            state_q     <= S_ARM;
            burst_cnt_q <= '0;
            short_err_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        S_ARM: begin
          if (rising_d) begin
            state_q <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          // Falling edge closes the burst; its last write lands this cycle.
          if (!AD_data_valid) begin
            if (k_q < DEPTH_K) begin
              short_err_q <= 1'b1;
            end
            burst_cnt_q <= burst_cnt_q + BC_W'(1);
            if ((burst_cnt_q + BC_W'(1)) == NBURST) begin
              state_q <= S_DUMP;
              full_q  <= 1'b1;
            end else begin
              state_q <= S_ARM;
            end
          end
        end
        S_DUMP: begin
          if (pop_d && out_last_q) begin
            state_q <= S_IDLE;
            full_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Datapath: accumulate pipeline, dump reads, output/skid registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_sample) begin
    if (reset) begin
      valid_prev_q   <= 1'b0;
      k_q            <= '0;
      wr_pend_q      <= 1'b0;
      wr_addr_q      <= '0;
      samp_q         <= '0;
      first_q        <= 1'b0;
      rd_cnt_q       <= '0;
      rd_pend_q      <= 1'b0;
      rd_pend_addr_q <= '0;
      out_v_q        <= 1'b0;
      out_data_q     <= '0;
      out_addr_q     <= '0;
      out_last_q     <= 1'b0;
      skid_v_q       <= 1'b0;
      skid_data_q    <= '0;
      skid_addr_q    <= '0;
      skid_last_q    <= 1'b0;
    end else begin
      valid_prev_q <= AD_data_valid;

      wr_pend_q <= take_d;
      if (take_d) begin
        wr_addr_q <= take_addr_d;
        samp_q    <= AD_data;
        first_q   <= (burst_cnt_q == '0);
        k_q       <= {1'b0, take_addr_d} + KW'(1);
      end

      // rd_cnt is idle at zero outside DUMP, so DUMP always starts at 0.
      if (state_q != S_DUMP) begin
        rd_cnt_q <= '0;
      end else if (issue_d) begin
        rd_cnt_q <= rd_cnt_q + KW'(1);
      end
      rd_pend_q <= issue_d;
      if (issue_d) begin
        rd_pend_addr_q <= rd_cnt_q[ADDR_W-1:0];
      end

      if (pop_d || !out_v_q) begin
        // Output slot is free: refill from skid first to keep order.
        if (skid_v_q) begin
          out_v_q    <= 1'b1;
          out_data_q <= skid_data_q;
          out_addr_q <= skid_addr_q;
          out_last_q <= skid_last_q;
          skid_v_q   <= rd_pend_q;
          if (rd_pend_q) begin
            skid_data_q <= in_data_d;
            skid_addr_q <= rd_pend_addr_q;
            skid_last_q <= in_last_d;
          end
        end else if (rd_pend_q) begin
          out_v_q    <= 1'b1;
          out_data_q <= in_data_d;
          out_addr_q <= rd_pend_addr_q;
          out_last_q <= in_last_d;
        end else begin
          out_v_q    <= 1'b0;
          out_last_q <= 1'b0;
        end
      end else if (rd_pend_q) begin
        // Stalled with a read landing: park it in the skid register.
        skid_v_q    <= 1'b1;
        skid_data_q <= in_data_d;
        skid_addr_q <= rd_pend_addr_q;
        skid_last_q <= in_last_d;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign Avg_Sram_full    = full_q;
  assign busy             = busy_q;
  assign short_err        = short_err_q;
  assign avg_if.avg_valid = out_v_q;
  assign avg_if.avg_data  = out_data_q;
  assign avg_if.avg_addr  = out_addr_q;
  assign avg_if.avg_last  = out_last_q;

endmodule

// File: tb/tb_ad_avg_accum.sv
// ---------------------------------------------------------------------------
// tb_ad_avg_accum
// Directed bursts drive a small averaging model; a negedge compare process
// checks every presented word against the model's expected stream.
// ---------------------------------------------------------------------------
module tb_ad_avg_accum;
  localparam int DATA_W   = 10;
  localparam int ADDR_W   = 4;
  localparam int DEPTH    = 16;
  localparam int AVG_LOG2 = 2;
  localparam int NB       = 1 << AVG_LOG2;

  logic              clk_sample = 1'b0;
  logic              reset = 1'b1;
  logic              AD_data_valid = 1'b0;
  logic [DATA_W-1:0] AD_data = '0;
  logic              avg_start = 1'b0;
  logic              Avg_Sram_full;
  logic              busy;
  logic              short_err;

  ad_avg_accum_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) avg_if ();

  ad_avg_accum #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .AVG_LOG2(AVG_LOG2)
  ) dut (
    .clk_sample   (clk_sample),
    .reset        (reset),
    .AD_data_valid(AD_data_valid),
    .AD_data      (AD_data),
    .avg_start    (avg_start),
    .Avg_Sram_full(Avg_Sram_full),
    .busy         (busy),
    .short_err    (short_err),
    .avg_if       (avg_if)
  );

  always #5 clk_sample = ~clk_sample;

  typedef struct {
    int data;
    int addr;
    int last;
  } word_t;

  word_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    fall_cyc = -100;
  int    full_rise_cyc = 0;
  bit    first_seen = 1'b0;
  int    acc_m[DEPTH];
  int    nb_m = 0;
  bit    exp_short = 1'b0;
  int    got[DEPTH];
  int    nwords = 0;
  int    first_hs = 0;
  int    last_hs = 0;
  bit    rand_ready = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_sample);
    #1;
  endtask

  initial forever begin
    @(posedge clk_sample);
    cyc++;
  end

  initial begin
    avg_if.avg_ready = 1'b1;
    forever begin
      @(posedge clk_sample);
      #1;
      avg_if.avg_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // One burst of len samples, value cval + kmul*k, followed by one low cycle.
  // The model averages only bursts marked as counted.
  task automatic do_burst(input int len, input int cval, input int kmul, input bit counted);
    for (int k = 0; k < len; k++) begin
      tick();
      AD_data_valid = 1'b1;
      AD_data = DATA_W'(cval + kmul * k);
    end
    tick();
    AD_data_valid = 1'b0;
    AD_data = '0;
    $display("burst len=%0d cval=%0d kmul=%0d counted=%0d", len, cval, kmul, counted);
    if (counted) begin
      for (int k = 0; k < len && k < DEPTH; k++)
        acc_m[k] = (nb_m == 0) ? (cval + kmul * k) : (acc_m[k] + cval + kmul * k);
      if (len < DEPTH) exp_short = 1'b1;
      nb_m++;
      if (nb_m == NB) begin
        fall_cyc = cyc;
        for (int i = 0; i < DEPTH; i++)
          exp_q.push_back('{data: acc_m[i] / NB, addr: i, last: int'(i == DEPTH - 1)});
        nb_m = 0;
      end
    end
  endtask

  task automatic start_avg();
    avg_start = 1'b1;
    exp_short = 1'b0;
    nb_m = 0;
    nwords = 0;
    for (int i = 0; i < DEPTH; i++) got[i] = -1;
    tick();
    avg_start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      tick();
      n++;
    end
    chk("done_timeout", int'(busy), 0);
    tick();
    tick();
    chk("words_left", exp_q.size(), 0);
    chk("words_recv", nwords, DEPTH);
    chk("short_err", int'(short_err), int'(exp_short));
    exp_q.delete();
  endtask

  // Compare process: checks each presented word, hold-while-stalled, and the
  // Avg_Sram_full timing around DUMP.
  initial begin
    bit stalled;
    bit chk_fall;
    bit prev_full;
    int sd, sa, sl;
    stalled = 0; chk_fall = 0; prev_full = 0; sd = 0; sa = 0; sl = 0;
    forever begin
      @(negedge clk_sample);
      if (reset) begin
        stalled = 0;
        chk_fall = 0;
        prev_full = 0;
      end else begin
        if (chk_fall) begin
          chk("full_fall", int'(Avg_Sram_full), 0);
          chk("busy_fall", int'(busy), 0);
          chk_fall = 0;
        end
        if (Avg_Sram_full && !prev_full) begin
          chk("full_rise_cyc", cyc, fall_cyc + 1);
          full_rise_cyc = cyc;
          first_seen = 0;
        end
        prev_full = Avg_Sram_full;
        if (stalled) begin
          chk("hold_valid", int'(avg_if.avg_valid), 1);
          chk("hold_data", int'(avg_if.avg_data), sd);
          chk("hold_addr", int'(avg_if.avg_addr), sa);
          chk("hold_last", int'(avg_if.avg_last), sl);
        end
        stalled = 0;
        if (avg_if.avg_valid) begin
          if (exp_q.size() == 0) begin
            chk("spurious_word", int'(avg_if.avg_valid), 0);
          end else begin
            if (!first_seen) begin
              chk("first_valid_lat", cyc - full_rise_cyc, 2);
              first_seen = 1;
            end
            chk("word_data", int'(avg_if.avg_data), exp_q[0].data);
            chk("word_addr", int'(avg_if.avg_addr), exp_q[0].addr);
            chk("word_last", int'(avg_if.avg_last), exp_q[0].last);
            chk("full_in_dump", int'(Avg_Sram_full), 1);
            if (avg_if.avg_ready) begin
              $display("word addr=%0d data=%0d last=%0d", avg_if.avg_addr, avg_if.avg_data, avg_if.avg_last);
              got[avg_if.avg_addr] = int'(avg_if.avg_data);
              if (nwords == 0) first_hs = cyc;
              last_hs = cyc;
              nwords++;
              if (exp_q[0].last != 0) chk_fall = 1;
              void'(exp_q.pop_front());
            end else begin
              stalled = 1;
              sd = int'(avg_if.avg_data);
              sa = int'(avg_if.avg_addr);
              sl = int'(avg_if.avg_last);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      acc_m[i] = 0;
      got[i] = -1;
    end
    reset = 1'b1;
    tick();
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_full", int'(Avg_Sram_full), 0);
    chk("rst_valid", int'(avg_if.avg_valid), 0);
    chk("rst_short", int'(short_err), 0);
    reset = 1'b0;
    tick();

    // Constant input, ready held high.
    start_avg();
    repeat (NB) do_burst(16, 100, 0, 1);
    wait_done();
    chk("const_w0", got[0], 100);
    chk("const_w15", got[15], 100);
    chk("const_thruput", last_hs - first_hs, DEPTH - 1);

    // Ramp with truncation: (4k+6)>>2 = k+1.
    start_avg();
    for (int b = 0; b < NB; b++) do_burst(16, b, 1, 1);
    wait_done();
    chk("ramp_w0", got[0], 1);
    chk("ramp_w15", got[15], 16);
    chk("ramp_thruput", last_hs - first_hs, DEPTH - 1);

    // Full scale.
    start_avg();
    repeat (NB) do_burst(16, 1023, 0, 1);
    wait_done();
    chk("fullscale_w7", got[7], 1023);

    // Random backpressure: 2k+75.
    rand_ready = 1'b1;
    start_avg();
    for (int b = 0; b < NB; b++) do_burst(16, b * 50, 2, 1);
    wait_done();
    rand_ready = 1'b0;
    chk("bp_w3", got[3], 81);

    // Short and long bursts.
    start_avg();
    do_burst(16, 40, 0, 1);
    do_burst(10, 80, 0, 1);
    do_burst(20, 0, 50, 1);
    do_burst(16, 40, 0, 1);
    wait_done();
    chk("bnd_short_err", int'(short_err), 1);
    chk("bnd_w0", got[0], 40);
    chk("bnd_w1", got[1], 52);
    chk("bnd_w10", got[10], 145);
    chk("bnd_w15", got[15], 207);

    // avg_start during a running burst, and avg_start while busy.
    AD_data_valid = 1'b1;
    AD_data = DATA_W'(500);
    tick();
    tick();
    start_avg();
    tick();
    tick();
    AD_data_valid = 1'b0;
    AD_data = '0;
    do_burst(16, 20, 0, 1);
    do_burst(16, 20, 0, 1);
    avg_start = 1'b1;
    tick();
    avg_start = 1'b0;
    do_burst(16, 20, 0, 1);
    do_burst(16, 20, 0, 1);
    wait_done();
    chk("midburst_w0", got[0], 20);
    chk("midburst_short", int'(short_err), 0);

    // Reset in ACCUM after two bursts.
    start_avg();
    do_burst(16, 300, 0, 0);
    do_burst(8, 100, 0, 0);
    AD_data_valid = 1'b1;
    AD_data = DATA_W'(5);
    tick();
    tick();
    tick();
    reset = 1'b1;
    AD_data_valid = 1'b0;
    AD_data = '0;
    tick();
    tick();
    chk("rst2_busy", int'(busy), 0);
    chk("rst2_full", int'(Avg_Sram_full), 0);
    chk("rst2_valid", int'(avg_if.avg_valid), 0);
    chk("rst2_data", int'(avg_if.avg_data), 0);
    chk("rst2_addr", int'(avg_if.avg_addr), 0);
    chk("rst2_last", int'(avg_if.avg_last), 0);
    chk("rst2_short", int'(short_err), 0);
    reset = 1'b0;
    tick();
    start_avg();
    repeat (NB) do_burst(16, 7, 0, 1);
    wait_done();
    chk("post_rst_w9", got[9], 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ad_avg_accum.md
# ad_avg_accum

Downstream of the AD sample-enable generator. Coherently averages 2^AVG_LOG2 consecutive acquisition bursts of AD samples, index by index, into an internal accumulator RAM. It then streams the averaged waveform out to the thickness-processing logic over a valid/ready handshake. While the result is held, it asserts Avg_Sram_full so that upstream acquisition can be gated.

## Interface
Parameters:
- DATA_W, 10: AD sample width, unsigned offset-binary.
- ADDR_W, 13: accumulator address width.
- DEPTH, 8192: samples per burst; must be ≤ 2^ADDR_W.
- AVG_LOG2, 4: log2 of bursts per average; legal range 0..6.

Ports (one clock, `clk_sample`; reset `reset` is synchronous, active-high):
- clk_sample  in  1  sample clock; all logic on rising edge.
- reset  in  1  synchronous active-high reset.
- AD_data_valid  in  1  high for each valid sample of a burst; a burst is one contiguous high run.
- AD_data  in  DATA_W  sample, qualified by AD_data_valid in the same cycle.
- avg_start  in  1  one-cycle pulse; begins a new average. Ignored unless in IDLE.
- Avg_Sram_full  out  1  high from entry to DUMP until the last output word is accepted.
- busy  out  1  high in every state except IDLE.
- short_err  out  1  sticky; set when any burst in the current average has fewer than DEPTH samples. Cleared by avg_start.
- avg_valid  out  1  output word valid.
- avg_ready  in  1  consumer accepts the word when avg_valid && avg_ready.
- avg_data  out  DATA_W  averaged sample.
- avg_addr  out  ADDR_W  sample index of avg_data.
- avg_last  out  1  high with the word at index DEPTH-1.

## Operation
States: IDLE, ARM, ACCUM, DUMP.
- IDLE → ARM on avg_start. On this transition:
  - burst_cnt clears to 0.
  - short_err clears.
- ARM waits for AD_data_valid to be low for at least one cycle, then high. The high cycle is sample 0, and the block enters ACCUM. A burst already in progress when avg_start arrives is discarded whole.
- ACCUM: each valid sample at index k is processed as follows.
  - When burst_cnt==0, acc[k] ← AD_data, which avoids a separate clear pass.
  - Otherwise, acc[k] ← acc[k] + AD_data.
  - k increments per valid sample. Samples with k ≥ DEPTH are dropped.
- Falling edge of AD_data_valid ends the burst.
  - If k < DEPTH, set short_err. Entries k..DEPTH-1 keep their prior contents.
  - Increment burst_cnt.
  - If burst_cnt reaches 2^AVG_LOG2, go to DUMP; otherwise return to ARM.
- DUMP reads acc[0..DEPTH-1] in order and presents avg_data = acc[i] >> AVG_LOG2 (truncating).
  - After the word with avg_last is accepted, go to IDLE.
  - AD_data_valid is ignored in DUMP.
- Arithmetic:
  - Accumulator width is DATA_W+AVG_LOG2, unsigned, so there is no overflow.
  - RAM is a single DEPTH × (DATA_W+AVG_LOG2) simple dual-port with 1-cycle read latency.
- reset in any state:
  - State goes to IDLE; counters and short_err clear.
  - All outputs go low/zero: Avg_Sram_full=0, busy=0, avg_valid=0, avg_data=0, avg_addr=0, avg_last=0.
  - RAM contents are don't-care.

## Timing
- Accumulate pipeline:
  - Cycle t: the sample is registered and RAM read address k is issued.
  - Cycle t+1: sum is formed and written to k.
  - Sequential addresses never collide, so no read-after-write hazard exists.
- Back-to-back bursts: AD_data_valid may rise again 1 cycle after falling. This requires ARM to accept a single low cycle, and the pending write completes in that cycle.
- The last write of the final burst completes before DUMP issues its first read.
- DUMP output:
  - First avg_valid is 2 cycles after entering DUMP.
  - With avg_ready held high, the block delivers one word per cycle, DEPTH words in DEPTH cycles.
  - avg_data, avg_addr and avg_last are held stable while avg_valid && !avg_ready. A skid register is required because of the RAM latency.
- Avg_Sram_full:
  - Rises in the cycle after the final burst's falling edge (the DUMP entry cycle).
  - Falls in the cycle after the last handshake.
- avg_start while busy: no effect.

## Test plan
Bench parameters: DEPTH=16, AVG_LOG2=2.
- Constant input: 4 bursts of 16 samples, AD_data=100, avg_ready=1 → 16 words of 100, avg_addr 0..15, avg_last at 15, short_err=0.
- Ramp plus truncation: bursts with AD_data=k+b for b=0..3 → avg_data[k] = (4k+6)>>2 = k+1.
- Full-scale: 4 bursts of 1023 → avg_data=1023, no wrap.
- Backpressure: toggle avg_ready randomly → no word lost or duplicated; data stable while stalled; Avg_Sram_full high throughout DUMP.
- Boundary bursts:
  - A 10-sample burst → short_err=1.
  - A 20-sample burst → samples 16..19 ignored.
  - avg_start during a high burst → that burst is not counted.
- Reset in ACCUM after 2 bursts, then a new avg_start → outputs zero after reset; the next average uses only the 4 new bursts.
